// File: rtl/uart_transmitter.sv
// UART transmitter: one-word holding buffer in front of a shift register,
// with the frame configuration latched at each frame load, and line-break generation.
//
// state  | meaning
// IDLE   | line high; waiting for a queued word or a break request
// START  | start bit, line low
// DATA   | data bits, LSB first
// PARITY | optional parity bit
// STOP   | one or two stop bits, line high
// BREAK  | line held low while sendBreak is asserted
module uart_transmitter (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  dataIn,
    input  logic        sendReq,
    output logic        ready,
    output logic        busy,
    output logic        frameDone,
    input  logic [1:0]  dataBits,
    input  logic        hasParity,
    input  logic [1:0]  parityMode,
    input  logic        extraStopBit,
    input  logic [23:0] clockDivisor,
    input  logic        sendBreak,
    output logic        tx
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } txState;

    txState      state;
    txState      stateNext;

    logic [7:0]  bufData;
    logic        bufFull;
    logic [7:0]  shiftReg;
    logic [2:0]  bitCnt;
    logic [23:0] divCnt;

    logic [1:0]  frmBits;
    logic        frmParity;
    logic [1:0]  frmParityMode;
    logic        frmStop2;
    logic [23:0] frmDiv;
    logic        parityBit;

    logic        txReg;
    logic        txNext;
    logic        frameDoneReg;

    logic        load;
    logic        frameEnd;
    logic        accept;
    logic        inFrame;
    logic        bitEnd;
    logic        lastData;
    logic        lastStop;
    logic [23:0] divReload;
    logic [23:0] loadDiv;
    logic [7:0]  dataMask;
    logic        wordParity;
    logic        parityCalc;

    assign inFrame   = (state == START) || (state == DATA) ||
                       (state == PARITY) || (state == STOP);
    assign bitEnd    = (divCnt == 24'd0);
    assign lastData  = (bitCnt == {1'b1, frmBits});
    assign lastStop  = (bitCnt == {2'b00, frmStop2});
    assign divReload = (frmDiv > 24'd1) ? frmDiv - 24'd1 : 24'd0;
    assign loadDiv   = (clockDivisor > 24'd1) ? clockDivisor - 24'd1 : 24'd0;

    // Parity is resolved at load time, so only the resulting bit is carried through the frame.
    assign dataMask   = 8'hFF >> (2'd3 - dataBits);
    assign wordParity = ^(bufData & dataMask);

    always_comb begin
        parityCalc = 1'b0;
        case (parityMode)
            2'd0:    parityCalc = wordParity;
            2'd1:    parityCalc = ~wordParity;
            2'd2:    parityCalc = 1'b1;
            default: parityCalc = 1'b0;
        endcase
    end

    // A load frees the buffer in the same cycle, so a new request can be taken alongside it.
    assign ready  = !bufFull || load;
    assign accept = sendReq && ready;
    assign busy   = (state != IDLE);
    assign tx        = txReg;
    assign frameDone = frameDoneReg;

    always_comb begin
        stateNext = state;
        load      = 1'b0;
        frameEnd  = 1'b0;
        case (state)
            IDLE: begin
                if (sendBreak) begin
                    stateNext = BREAK;
                end else if (bufFull) begin
                    load      = 1'b1;
                    stateNext = START;
                end
            end
            START: begin
                if (bitEnd) stateNext = DATA;
            end
            DATA: begin
                if (bitEnd && lastData) stateNext = frmParity ? PARITY : STOP;
            end
            PARITY: begin
                if (bitEnd) stateNext = STOP;
            end
            STOP: begin
                if (bitEnd && lastStop) begin
                    frameEnd = 1'b1;
                    if (bufFull && !sendBreak) begin
                        load      = 1'b1;
                        stateNext = START;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            BREAK: begin
                if (!sendBreak) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // tx is registered from the next state so the line never glitches.
    always_comb begin
        txNext = 1'b1;
        case (stateNext)
            START:   txNext = 1'b0;
            DATA:    txNext = ((state == DATA) && bitEnd) ? shiftReg[1] : shiftReg[0];
            PARITY:  txNext = parityBit;
            BREAK:   txNext = 1'b0;
            default: txNext = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txReg         <= 1'b1;
            frameDoneReg  <= 1'b0;
            bufData       <= 8'd0;
            bufFull       <= 1'b0;
            shiftReg      <= 8'd0;
            bitCnt        <= 3'd0;
            divCnt        <= 24'd0;
            frmBits       <= 2'd0;
            frmParity     <= 1'b0;
            frmParityMode <= 2'd0;
            frmStop2      <= 1'b0;
            frmDiv        <= 24'd0;
            parityBit     <= 1'b0;
        end else begin
            txReg        <= txNext;
            frameDoneReg <= frameEnd;

            if (accept) begin
                bufData <= dataIn;
                bufFull <= 1'b1;
            end else if (load) begin
                bufFull <= 1'b0;
            end

            if (load) begin
                shiftReg      <= bufData;
                frmBits       <= dataBits;
                frmParity     <= hasParity;
                frmParityMode <= parityMode;
                frmStop2      <= extraStopBit;
                frmDiv        <= clockDivisor;
                parityBit     <= parityCalc;
                divCnt        <= loadDiv;
                bitCnt        <= 3'd0;
            end else if (inFrame) begin
                if (bitEnd) begin
                    divCnt <= divReload;
                    if (state == DATA) begin
                        if (lastData) begin
                            bitCnt <= 3'd0;
                        end else begin
                            bitCnt   <= bitCnt + 3'd1;
                            shiftReg <= {1'b0, shiftReg[7:1]};
                        end
                    end else if (state == STOP) begin
                        bitCnt <= lastStop ? 3'd0 : bitCnt + 3'd1;
                    end
                end else begin
                    divCnt <= divCnt - 24'd1;
                end
            end
        end
    end

endmodule
